// File: rtl/reg_file_sb.sv
// reg_file_sb -- LC-3b general-purpose register file with a per-register
// scoreboard and an NZP condition-code register.
//
// Optional feature macro: REG_FILE_BYPASS_EN
//   defined   : write-to-read forwarding. A same-cycle write to a read address
//               drives that port's data with the write data and clears its busy
//               indication.
//   undefined : read data and busy bits come from registered state only.
//
// Ports:
//   clk, reset        core clock; synchronous active-high reset
//   raddr1/raddr2     read addresses
//   out1/out2         combinational read data
//   busy1/busy2       scoreboard bit of the register at raddr1/raddr2
//   we, waddr, in     write port (active-high enable)
//   set_cc            update cc from in when we is high
//   cc                {N,Z,P}, registered
//   rsv, rsv_addr     reserve (mark busy) a register
//   rsv_ok            combinational: a reservation at rsv_addr would be accepted
//   rsv_err           registered one-cycle pulse: a reservation was rejected
//
// Handshake note: a reservation is accepted in the cycle where rsv and rsv_ok
// are both high. rsv_ok is low only when the target is already busy and is not
// being written in the same cycle. A rejected reservation leaves state alone
// and raises rsv_err for the following cycle.
module reg_file_sb #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [WIDTH-1:0]  out1,
  output logic [WIDTH-1:0]  out2,
  output logic              busy1,
  output logic              busy2,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  in,
  input  logic              set_cc,
  output logic [2:0]        cc,
  input  logic              rsv,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ok,
  output logic              rsv_err
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;
  logic [2:0]       cc_from_in;

  // A busy register may be re-reserved in the same cycle its result is written.
  assign rsv_ok = ~busy[rsv_addr] | (we & (waddr == rsv_addr));

  always_comb begin
    if (in[WIDTH-1])   cc_from_in = 3'b100;
    else if (in == '0) cc_from_in = 3'b010;
    else               cc_from_in = 3'b001;
  end

  // Write clears busy; an accepted reservation sets it and wins over the clear.
  always_comb begin
    busy_next = busy;
    if (we) busy_next[waddr] = 1'b0;
    if (rsv && rsv_ok) busy_next[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy    <= '0;
      cc      <= 3'b010;
      rsv_err <= 1'b0;
    end else begin
      if (we) begin
        regs[waddr] <= in;
        if (set_cc) cc <= cc_from_in;
      end
      busy    <= busy_next;
      rsv_err <= rsv & ~rsv_ok;
    end
  end

`ifdef REG_FILE_BYPASS_EN
  always_comb begin
    out1  = regs[raddr1];
    out2  = regs[raddr2];
    busy1 = busy[raddr1];
    busy2 = busy[raddr2];
    if (we && (waddr == raddr1)) begin
      out1  = in;
      busy1 = 1'b0;
    end
    if (we && (waddr == raddr2)) begin
      out2  = in;
      busy2 = 1'b0;
    end
  end
`else
  assign out1  = regs[raddr1];
  assign out2  = regs[raddr2];
  assign busy1 = busy[raddr1];
  assign busy2 = busy[raddr2];
`endif

endmodule
